// File: rtl/mips_div_seq.sv
// Sequential restoring divider for MIPS DIV/DIVU: one quotient bit per clock on
// operand magnitudes, then a sign fix-up cycle that writes the HI/LO pair.
module mips_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output logic             DIV_ZERO
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dzo_q, dzo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign a_neg = SIGNED & A[WIDTH-1];
  assign b_neg = SIGNED & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // Remainder stays below the divisor, so the extra top bit keeps the trial
  // subtraction's sign bit meaningful even for a 0x80000000 magnitude.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs_q};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      dzo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dzo_q    <= dzo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dzo_d    = dzo_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          rem_d = '0;
          if (B == '0) begin
            // Divide-by-zero: park the raw dividend in the quotient register for HI.
            state_d  = S_FIX;
            dz_d     = 1'b1;
            quo_d    = A;
            sign_a_d = 1'b0;
            sign_b_d = 1'b0;
          end else begin
            state_d  = S_RUN;
            dz_d     = 1'b0;
            quo_d    = a_mag;
            dvs_d    = b_mag;
            sign_a_d = a_neg;
            sign_b_d = b_neg;
            cnt_d    = CNT_W'(WIDTH);
          end
        end
      end
      S_RUN: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (dz_q) begin
          lo_d  = '1;
          hi_d  = quo_q;
          dzo_d = 1'b1;
        end else begin
          lo_d  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
          hi_d  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dzo_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY     = (state_q == S_RUN) || (state_q == S_FIX);
  assign DONE     = (state_q == S_DONE);
  assign LO       = lo_q;
  assign HI       = hi_q;
  assign DIV_ZERO = dzo_q;

endmodule

// File: doc/mips_div_seq.md
Name: mips_div_seq

Overview:
- Multi-cycle 32-bit integer divider for the MIPS datapath; serves DIV/DIVU and writes the HI/LO result pair.
- Restoring radix-2 algorithm, one quotient bit per clock, operating on operand magnitudes with a final sign fix-up.
- Sits beside the combinational ALU; the control unit stalls on BUSY and captures results on DONE.

Parameters:
WIDTH, 32, operand/result width in bits (only 32 is verified)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous active-high reset
START  input  1  request; sampled only in IDLE
SIGNED  input  1  1 = DIV (two's complement), 0 = DIVU; captured with START
A  input  WIDTH  dividend; captured with START
B  input  WIDTH  divisor; captured with START
BUSY  output  1  high while a division is in progress
DONE  output  1  one-cycle pulse; LO/HI/DIV_ZERO valid from this cycle
LO  output  WIDTH  quotient
HI  output  WIDTH  remainder
DIV_ZERO  output  1  set with DONE when B was 0; held until next completion

Behaviour:
- Reset: RST high asynchronously forces state IDLE, counter 0, all internal registers 0. Outputs: BUSY=0, DONE=0, LO=0, HI=0, DIV_ZERO=0. Reset mid-operation aborts the division with no DONE pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE -> RUN: START=1 at an edge and B!=0.
  - Latch sign flags: signA = SIGNED & A[31], signB = SIGNED & B[31].
  - Load magnitude |A| into the quotient/shift register and |B| into the divisor register. Magnitudes are taken only when the corresponding sign flag is set; otherwise the operand is used as is.
  - Clear the partial remainder (WIDTH+1 bits); set counter = WIDTH; BUSY=1.
- IDLE -> FIX: START=1 and B==0.
  - Divide-by-zero path; RUN is skipped.
- RUN, each cycle:
  - Shift {rem, quo} left by 1 and compute trial = rem - divisor.
  - If trial is non-negative: rem = trial, quo[0] = 1. Otherwise rem is unchanged and quo[0] = 0.
  - Decrement counter. When the counter reaches 1 at an edge, go to FIX. RUN lasts exactly WIDTH cycles.
- FIX, one cycle:
  - LO = (signA ^ signB) ? -quo : quo.
  - HI = signA ? -rem : rem. Truncating division: the remainder takes the sign of the dividend.
  - DIV_ZERO = 0.
  - Divide-by-zero path instead: LO = all ones, HI = captured A, DIV_ZERO = 1.
  - Next state: DONE.
- DONE, one cycle: DONE=1, BUSY=0; next state IDLE.
- BUSY=1 in RUN and FIX.
- Latency from START edge to DONE cycle:
  - Normal: WIDTH+2 clocks (34 at default).
  - Divide-by-zero: 2 clocks.
- START while not in IDLE (RUN, FIX, DONE) is ignored. A, B and SIGNED may change freely after capture.
- A new START may be accepted on the edge that leaves DONE only if the state is IDLE. Back-to-back throughput is therefore one division per WIDTH+3 cycles.
- LO/HI/DIV_ZERO change only in FIX (and on reset); they hold their values otherwise.
- Overflow case: SIGNED, A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0. This is wrapping behaviour with no flag.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned. The partial remainder is WIDTH+1 bits wide so the compare never overflows.
- All arithmetic is modulo 2^WIDTH; no X propagation from unselected operands.

Test Plan:
1. Unsigned 100/7: SIGNED=0, A=100, B=7, START one cycle -> BUSY for 33 cycles, DONE on cycle 34, LO=14, HI=2, DIV_ZERO=0.
2. Signed -7/2: SIGNED=1, A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also 7/-2 -> LO=0xFFFFFFFD, HI=1.
3. Large unsigned and overflow: DIVU 0xFFFFFFFF/1 -> LO=0xFFFFFFFF, HI=0. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Divide by zero: A=0x12345678, B=0 -> DONE 2 cycles after START, LO=0xFFFFFFFF, HI=0x12345678, DIV_ZERO=1. A following 10/3 clears DIV_ZERO with LO=3, HI=1.
5. START during BUSY: issue 100/7, pulse START with A=9, B=3 at cycle 10 -> ignored; single DONE at cycle 34 with LO=14, HI=2.
6. Reset mid-op: start 1000/10, assert RST at cycle 15 for a partial cycle (asynchronous) -> BUSY, DONE, LO, HI drop to 0 immediately, no DONE pulse. A new 1000/10 after release completes with LO=100, HI=0.
